bp_fpga_axil_responder: RTL
===========================

BP_FPGA_AXIL_RESPONDER -- requirements
Module: bp_fpga_axil_responder

Interface
REQ-001 The block SHALL have parameter addr_width_p, default 64, meaning AXI4-Lite address width.
REQ-002 The block SHALL have parameter data_width_p, default 64, meaning AXI4-Lite data width; strobe width is data_width_p/8.
REQ-003 The block SHALL have parameter num_regs_p, default 8 (power of 2), meaning the register count.
REQ-004 The block SHALL have parameter base_addr_p, default 0, meaning the window base address, aligned to num_regs_p*data_width_p/8.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 The block SHALL have clk_i, input, 1 bit: the clock.
REQ-007 The block SHALL have reset_i, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have write-address ports s_axil_awaddr_i (addr_width_p), s_axil_awprot_i (3, ignored), s_axil_awvalid_i (1) and s_axil_awready_o (1).
REQ-009 The block SHALL have write-data ports s_axil_wdata_i (data_width_p), s_axil_wstrb_i (data_width_p/8), s_axil_wvalid_i (1) and s_axil_wready_o (1).
REQ-010 The block SHALL have write-response ports s_axil_bresp_o (2), s_axil_bvalid_o (1) and s_axil_bready_i (1).
REQ-011 The block SHALL have read-address ports s_axil_araddr_i (addr_width_p), s_axil_arprot_i (3, ignored), s_axil_arvalid_i (1) and s_axil_arready_o (1).
REQ-012 The block SHALL have read-data ports s_axil_rdata_o (data_width_p), s_axil_rresp_o (2), s_axil_rvalid_o (1) and s_axil_rready_i (1).
REQ-013 The block SHALL have regs_o, output, num_regs_p*data_width_p bits: all registers, with register k at bits [k*data_width_p +: data_width_p].
REQ-014 The block SHALL have wr_v_o, output, 1 bit: a one-cycle pulse on each committed register write.
REQ-015 The block SHALL have wr_idx_o, output, log2(num_regs_p) bits: the index of the committed write, valid with wr_v_o.

Function
REQ-016 The write and read channels SHALL operate independently and concurrently, each allowing one outstanding transaction.
REQ-017 The write FSM SHALL have four states: W_IDLE, W_HAVE_AW (address held), W_HAVE_W (data held) and W_RESP (bvalid high).
REQ-018 s_axil_awready_o SHALL be 1 only in W_IDLE and W_HAVE_W; s_axil_wready_o SHALL be 1 only in W_IDLE and W_HAVE_AW.
REQ-019 AW and W SHALL be accepted in either order or in the same cycle, and neither valid may depend on the other being accepted.
REQ-020 The write SHALL commit on the clock edge at which the second of AW/W handshakes, or at which both handshake together, and the FSM SHALL enter W_RESP.
REQ-021 On commit, a write SHALL be decoded OK when addr-base_addr_p is below num_regs_p*data_width_p/8 and addr[log2(data_width_p/8)-1:0] is 0.
REQ-022 An OK write SHALL write byte lanes whose wstrb bit is 1, leave other lanes unchanged, and pulse wr_v_o/wr_idx_o in the cycle after commit.
REQ-023 A decode-fail write SHALL leave all registers unchanged, SHALL NOT pulse wr_v_o, and SHALL return bresp=SLVERR (2'b10).
REQ-024 In W_RESP, bresp (OKAY=2'b00 or SLVERR) SHALL hold stable with bvalid until bready=1, and the FSM SHALL then return to W_IDLE.
REQ-025 Minimum write latency SHALL be: AW+W handshake in cycle N, then regs_o updated and bvalid=1 in cycle N+1, with the next AW accepted no earlier than the cycle after B completes.
REQ-026 The read FSM SHALL have two states: R_IDLE (arready=1) and R_RESP (rvalid=1, arready=0).
REQ-027 An AR handshake in cycle N SHALL register rdata/rresp, with rvalid=1 in cycle N+1 held stable until rready=1.
REQ-028 A decode-fail read SHALL return rdata=0 and rresp=SLVERR.
REQ-029 A read and a commit to the same register on the same edge SHALL return the pre-write value.
REQ-030 A zero wstrb SHALL be a legal OK write: no bytes change, but wr_v_o still pulses.

Reset
REQ-031 While reset_i=1, both FSMs SHALL be in their IDLE states.
REQ-032 While reset_i=1, all registers SHALL be 0 and bvalid, rvalid and wr_v_o SHALL be 0.
REQ-033 While reset_i=1, bresp, rresp and rdata SHALL be 0, and awready, wready and arready SHALL be 0.
REQ-034 Ready outputs SHALL first rise in the cycle after reset_i deasserts.
REQ-035 Reset asserted mid-transaction SHALL discard held AW/W and pending B/R without committing them.

Structure
REQ-036 The AXI response codes (OKAY, SLVERR) and the write/read FSM state enums SHALL be placed in the shared package bp_fpga_pkg.
REQ-037 The write-channel FSM with its AW/W holding registers SHALL be the sub-module bp_fpga_axil_wchan; the read path and register file SHALL stay in the top.

Verification
REQ-038 The bench SHALL drive AW and W in the same cycle to addr 0x08, data 0xDEADBEEF_CAFEF00D, wstrb 0xFF, and check bvalid=1 and bresp=0 at N+1, reg1=0xDEADBEEF_CAFEF00D and wr_idx_o=1.
REQ-039 The bench SHALL drive W 3 cycles before AW to addr 0x10, wstrb 0x0F, data 0x11111111_22222222 onto reg2=0xAAAAAAAA_BBBBBBBB, and check reg2=0xAAAAAAAA_22222222.
REQ-040 The bench SHALL write to addr 0x40 (out of range) and to addr 0x0C (misaligned), and check bresp=2'b10 with regs unchanged and no wr_v_o pulse.
REQ-041 The bench SHALL hold bready=0 and rready=0 for 5 cycles, and check that bvalid/rvalid, bresp, rresp and rdata stay stable and that awready, wready and arready stay 0.
REQ-042 The bench SHALL read addr 0x08 on the same edge as a write of 0x5 to it, and check rdata is the old value, with a following read returning 0x5.
REQ-043 The bench SHALL assert reset_i while in W_HAVE_AW, and check after reset that all regs are 0, bvalid=0, and a fresh write completes normally.

Source files
------------

// File: rtl/bp_fpga_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state encodings
// for the bp_fpga register responder.
package bp_fpga_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

endpackage

// File: rtl/bp_fpga_axil_responder_if.sv
// AXI4-Lite channel bundle (protection bits are ignored by the responder and
// stay on the top-level ports); wr is the write-channel-only slave view.
interface bp_fpga_axil_responder_if #(
  parameter int addr_width_p = 64,
  parameter int data_width_p = 64
);
  logic [addr_width_p-1:0]   awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [addr_width_p-1:0]   araddr;
  logic                      arvalid;
  logic                      arready;
  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport wr (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/bp_fpga_axil_wchan.sv
// Write-channel FSM: joins AW and W in any order, decodes the target and
// presents a one-cycle commit to the register file; B held until bready.
module bp_fpga_axil_wchan
  import bp_fpga_pkg::*;
#(
  parameter int                    addr_width_p = 64,
  parameter int                    data_width_p = 64,
  parameter int                    num_regs_p   = 8,
  parameter logic [addr_width_p-1:0] base_addr_p = '0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            en_i,
  bp_fpga_axil_responder_if.wr            axil,
  output logic                            commit_v_o,
  output logic                            commit_ok_o,
  output logic [$clog2(num_regs_p)-1:0]   commit_idx_o,
  output logic [data_width_p-1:0]         commit_data_o,
  output logic [data_width_p/8-1:0]       commit_strb_o
);

  localparam int strb_w_lp = data_width_p / 8;
  localparam int idx_w_lp  = $clog2(num_regs_p);
  localparam int lsb_lp    = $clog2(strb_w_lp);
  localparam logic [addr_width_p-1:0] span_lp = addr_width_p'(num_regs_p * strb_w_lp);

  w_state_e                state_q, state_d;
  logic [addr_width_p-1:0] awaddr_q, awaddr_d;
  logic [data_width_p-1:0] wdata_q, wdata_d;
  logic [strb_w_lp-1:0]    wstrb_q, wstrb_d;
  axi_resp_e               bresp_q, bresp_d;

  logic                    aw_hs, w_hs, commit_v, dec_ok;
  logic [addr_width_p-1:0] addr_sel, dec_off;

  assign axil.awready = en_i && (state_q == W_IDLE || state_q == W_HAVE_W);
  assign axil.wready  = en_i && (state_q == W_IDLE || state_q == W_HAVE_AW);
  assign axil.bvalid  = (state_q == W_RESP);
  assign axil.bresp   = bresp_q;

  assign aw_hs = axil.awvalid && en_i && (state_q == W_IDLE || state_q == W_HAVE_W);
  assign w_hs  = axil.wvalid  && en_i && (state_q == W_IDLE || state_q == W_HAVE_AW);

  // The half that arrived first comes from its holding register.
  assign addr_sel      = (state_q == W_HAVE_AW) ? awaddr_q : axil.awaddr;
  assign commit_data_o = (state_q == W_HAVE_W)  ? wdata_q  : axil.wdata;
  assign commit_strb_o = (state_q == W_HAVE_W)  ? wstrb_q  : axil.wstrb;

  assign commit_v = (state_q == W_IDLE    && aw_hs && w_hs) ||
                    (state_q == W_HAVE_AW && w_hs) ||
                    (state_q == W_HAVE_W  && aw_hs);

  assign dec_off      = addr_sel - base_addr_p;
  assign dec_ok       = (dec_off < span_lp) && (addr_sel[lsb_lp-1:0] == '0);
  assign commit_v_o   = commit_v;
  assign commit_ok_o  = dec_ok;
  assign commit_idx_o = dec_off[lsb_lp +: idx_w_lp];

  always_comb begin
    state_d  = state_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    if (commit_v) begin
      state_d = W_RESP;
      bresp_d = dec_ok ? AXI_OKAY : AXI_SLVERR;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_d = axil.awaddr;
            state_d  = W_HAVE_AW;
          end else if (w_hs) begin
            wdata_d = axil.wdata;
            wstrb_d = axil.wstrb;
            state_d = W_HAVE_W;
          end
        end
        W_RESP:  if (axil.bready) state_d = W_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= AXI_OKAY;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

endmodule

// File: rtl/bp_fpga_axil_responder.sv
// AXI4-Lite register-file responder: num_regs_p registers exposed on regs_o,
// independent single-outstanding write and read channels.
module bp_fpga_axil_responder
  import bp_fpga_pkg::*;
#(
  parameter int                    addr_width_p = 64,
  parameter int                    data_width_p = 64,
  parameter int                    num_regs_p   = 8,
  parameter logic [addr_width_p-1:0] base_addr_p = '0
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [addr_width_p-1:0]            s_axil_awaddr_i,
  input  logic [2:0]                         s_axil_awprot_i,
  input  logic                               s_axil_awvalid_i,
  output logic                               s_axil_awready_o,
  input  logic [data_width_p-1:0]            s_axil_wdata_i,
  input  logic [data_width_p/8-1:0]          s_axil_wstrb_i,
  input  logic                               s_axil_wvalid_i,
  output logic                               s_axil_wready_o,
  output logic [1:0]                         s_axil_bresp_o,
  output logic                               s_axil_bvalid_o,
  input  logic                               s_axil_bready_i,
  input  logic [addr_width_p-1:0]            s_axil_araddr_i,
  input  logic [2:0]                         s_axil_arprot_i,
  input  logic                               s_axil_arvalid_i,
  output logic                               s_axil_arready_o,
  output logic [data_width_p-1:0]            s_axil_rdata_o,
  output logic [1:0]                         s_axil_rresp_o,
  output logic                               s_axil_rvalid_o,
  input  logic                               s_axil_rready_i,
  output logic [num_regs_p*data_width_p-1:0] regs_o,
  output logic                               wr_v_o,
  output logic [$clog2(num_regs_p)-1:0]      wr_idx_o
);

  localparam int strb_w_lp = data_width_p / 8;
  localparam int idx_w_lp  = $clog2(num_regs_p);
  localparam int lsb_lp    = $clog2(strb_w_lp);
  localparam logic [addr_width_p-1:0] span_lp = addr_width_p'(num_regs_p * strb_w_lp);

  bp_fpga_axil_responder_if #(
    .addr_width_p(addr_width_p),
    .data_width_p(data_width_p)
  ) axil ();

  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

  assign axil.awaddr      = s_axil_awaddr_i;
  assign axil.awvalid     = s_axil_awvalid_i;
  assign axil.wdata       = s_axil_wdata_i;
  assign axil.wstrb       = s_axil_wstrb_i;
  assign axil.wvalid      = s_axil_wvalid_i;
  assign axil.bready      = s_axil_bready_i;
  assign axil.araddr      = s_axil_araddr_i;
  assign axil.arvalid     = s_axil_arvalid_i;
  assign axil.rready      = s_axil_rready_i;
  assign s_axil_awready_o = axil.awready;
  assign s_axil_wready_o  = axil.wready;
  assign s_axil_bresp_o   = axil.bresp;
  assign s_axil_bvalid_o  = axil.bvalid;
  assign s_axil_arready_o = axil.arready;
  assign s_axil_rdata_o   = axil.rdata;
  assign s_axil_rresp_o   = axil.rresp;
  assign s_axil_rvalid_o  = axil.rvalid;

  // Holds all readies low until the first edge after reset releases.
  logic en_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) en_q <= 1'b0;
    else         en_q <= 1'b1;
  end

  logic                      commit_v, commit_ok;
  logic [idx_w_lp-1:0]       commit_idx;
  logic [data_width_p-1:0]   commit_data;
  logic [strb_w_lp-1:0]      commit_strb;

  bp_fpga_axil_wchan #(
    .addr_width_p(addr_width_p),
    .data_width_p(data_width_p),
    .num_regs_p  (num_regs_p),
    .base_addr_p (base_addr_p)
  ) u_wchan (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .en_i         (en_q),
    .axil         (axil),
    .commit_v_o   (commit_v),
    .commit_ok_o  (commit_ok),
    .commit_idx_o (commit_idx),
    .commit_data_o(commit_data),
    .commit_strb_o(commit_strb)
  );

  logic [num_regs_p-1:0][data_width_p-1:0] regs_q;
  logic                                    wr_v_q;
  logic [idx_w_lp-1:0]                     wr_idx_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      regs_q   <= '0;
      wr_v_q   <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      wr_v_q <= commit_v && commit_ok;
      if (commit_v && commit_ok) begin
        wr_idx_q <= commit_idx;
        for (int b = 0; b < strb_w_lp; b++) begin
          if (commit_strb[b]) regs_q[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
        end
      end
    end
  end

  assign regs_o   = regs_q;
  assign wr_v_o   = wr_v_q;
  assign wr_idx_o = wr_idx_q;

  r_state_e                r_state_q, r_state_d;
  logic [data_width_p-1:0] rdata_q, rdata_d;
  axi_resp_e               rresp_q, rresp_d;
  logic                    ar_hs, ar_ok;
  logic [addr_width_p-1:0] ar_off;
  logic [idx_w_lp-1:0]     ar_idx;

  assign axil.arready = en_q && (r_state_q == R_IDLE);
  assign axil.rvalid  = (r_state_q == R_RESP);
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;

  assign ar_hs  = axil.arvalid && en_q && (r_state_q == R_IDLE);
  assign ar_off = axil.araddr - base_addr_p;
  assign ar_ok  = (ar_off < span_lp) && (axil.araddr[lsb_lp-1:0] == '0);
  assign ar_idx = ar_off[lsb_lp +: idx_w_lp];

  // Samples regs_q before any same-edge write lands, so reads see the old value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          rdata_d   = ar_ok ? regs_q[ar_idx] : '0;
          rresp_d   = ar_ok ? AXI_OKAY : AXI_SLVERR;
        end
      end
      R_RESP:  if (axil.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= AXI_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
